// File: rtl/piso.sv
// piso: parallel-in, serial-out converter driving a two-wire, I2C-style link.
//
// A 4-bit word is accepted on a one-cycle d_en pulse while idle. It is then
// sent MSB-first as a frame: a start condition, four data bits with scl
// low/high phases, and a stop condition. Every FSM state is held for
// PHASE_CYCLES cycles of sclk.
//
// Ports:
//   sclk   in   1  system clock, rising edge active
//   rst    in   1  asynchronous reset, active low
//   d_en   in   1  load request, sampled only in IDLE
//   data   in   4  parallel word, captured when d_en is accepted
//   scl    out  1  serial clock line (registered)
//   sda    out  1  serial data line (registered)
//   state  out  4  current FSM state encoding (registered)
module piso #(
    parameter int unsigned PHASE_CYCLES = 1
) (
    input  logic       sclk,
    input  logic       rst,
    input  logic       d_en,
    input  logic [3:0] data,
    output logic       scl,
    output logic       sda,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        IDLE  = 4'd0,
        START = 4'd1,
        B3L   = 4'd2,
        B3H   = 4'd3,
        B2L   = 4'd4,
        B2H   = 4'd5,
        B1L   = 4'd6,
        B1H   = 4'd7,
        B0L   = 4'd8,
        B0H   = 4'd9,
        STOPL = 4'd10,
        STOPH = 4'd11
    } state_t;

    localparam logic [7:0] PHASE_LAST = 8'(PHASE_CYCLES - 1);

    state_t     state_reg, state_next;
    logic [3:0] d_reg, d_next;
    logic [7:0] cnt_reg, cnt_next;
    logic       scl_reg, scl_next;
    logic       sda_reg, sda_next;
    logic       phase_done;

    assign phase_done = (cnt_reg == PHASE_LAST);

    always_ff @(posedge sclk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            d_reg     <= 4'd0;
            cnt_reg   <= 8'd0;
            scl_reg   <= 1'b1;
            sda_reg   <= 1'b1;
        end else begin
            state_reg <= state_next;
            d_reg     <= d_next;
            cnt_reg   <= cnt_next;
            scl_reg   <= scl_next;
            sda_reg   <= sda_next;
        end
    end

    // Next state, captured word and phase counter.
    always_comb begin
        state_next = state_reg;
        d_next     = d_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (d_en) begin
                    d_next     = data;
                    state_next = START;
                end
            end
            START, B3L, B3H, B2L, B2H, B1L, B1H, B0L, B0H, STOPL: begin
                if (phase_done) begin
                    state_next = state_t'(state_reg + 4'd1);
                end
            end
            STOPH: begin
                if (phase_done) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        // The counter restarts on every state change and idles at zero.
        if (state_next != state_reg || state_reg == IDLE) begin
            cnt_next = 8'd0;
        end else begin
            cnt_next = cnt_reg + 8'd1;
        end
    end

    // Line levels are decoded from the upcoming state and word so that the
    // registered outputs line up with the state register on the same edge.
    always_comb begin
        scl_next = 1'b1;
        sda_next = 1'b1;
        case (state_next)
            IDLE:  begin scl_next = 1'b1; sda_next = 1'b1;      end
            START: begin scl_next = 1'b1; sda_next = 1'b0;      end
            B3L:   begin scl_next = 1'b0; sda_next = d_next[3]; end
            B3H:   begin scl_next = 1'b1; sda_next = d_next[3]; end
            B2L:   begin scl_next = 1'b0; sda_next = d_next[2]; end
            B2H:   begin scl_next = 1'b1; sda_next = d_next[2]; end
            B1L:   begin scl_next = 1'b0; sda_next = d_next[1]; end
            B1H:   begin scl_next = 1'b1; sda_next = d_next[1]; end
            B0L:   begin scl_next = 1'b0; sda_next = d_next[0]; end
            B0H:   begin scl_next = 1'b1; sda_next = d_next[0]; end
            STOPL: begin scl_next = 1'b0; sda_next = 1'b0;      end
            STOPH: begin scl_next = 1'b1; sda_next = 1'b0;      end
            default: begin scl_next = 1'b1; sda_next = 1'b1;    end
        endcase
    end

    assign scl   = scl_reg;
    assign sda   = sda_reg;
    assign state = state_reg;

endmodule

// File: tb/tb_piso.sv
// Directed testbench for piso: one instance with the default phase length and
// one with PHASE_CYCLES=3. Outputs are sampled 1 ns after each rising edge.
module tb_piso;

    logic       sclk;
    logic       rst;
    logic       d_en_a, d_en_b;
    logic [3:0] data_a, data_b;
    logic       scl_a, sda_a, scl_b, sda_b;
    logic [3:0] state_a, state_b;

    int vectors = 0;
    int errors  = 0;

    piso dut_a (
        .sclk  (sclk),
        .rst   (rst),
        .d_en  (d_en_a),
        .data  (data_a),
        .scl   (scl_a),
        .sda   (sda_a),
        .state (state_a)
    );

    piso #(.PHASE_CYCLES(3)) dut_b (
        .sclk  (sclk),
        .rst   (rst),
        .d_en  (d_en_b),
        .data  (data_b),
        .scl   (scl_b),
        .sda   (sda_b),
        .state (state_b)
    );

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    // Expected line levels for a state, from the protocol table.
    function automatic logic exp_scl(input logic [3:0] st);
        case (st)
            4'd2, 4'd4, 4'd6, 4'd8, 4'd10: exp_scl = 1'b0;
            default:                       exp_scl = 1'b1;
        endcase
    endfunction

    function automatic logic exp_sda(input logic [3:0] st, input logic [3:0] w);
        case (st)
            4'd0:        exp_sda = 1'b1;
            4'd2, 4'd3:  exp_sda = w[3];
            4'd4, 4'd5:  exp_sda = w[2];
            4'd6, 4'd7:  exp_sda = w[1];
            4'd8, 4'd9:  exp_sda = w[0];
            default:     exp_sda = 1'b0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge sclk);
        #1;
    endtask

    // Check all three outputs of instance a against state st carrying word w.
    task automatic chk_a(input string tag, input logic [3:0] st, input logic [3:0] w);
        chk({tag, ".state"}, state_a, st);
        chk({tag, ".scl"}, {3'b0, scl_a}, {3'b0, exp_scl(st)});
        chk({tag, ".sda"}, {3'b0, sda_a}, {3'b0, exp_sda(st, w)});
    endtask

    // Hand-written sequences for the 4'b1101 frame, states 1..11 then IDLE.
    logic [11:0] frame_sda = 12'b0111_1001_1001;
    logic [11:0] frame_scl = 12'b1010_1010_1011;
    logic [3:0]  bits;

    initial begin
        rst    = 1'b0;
        d_en_a = 1'b0;
        d_en_b = 1'b0;
        data_a = 4'd0;
        data_b = 4'd0;

        // Reset held for two cycles, then released with d_en low.
        repeat (2) begin
            step;
            chk_a("reset", 4'd0, 4'd0);
            chk("reset_b.state", state_b, 4'd0);
        end
        rst = 1'b1;
        repeat (5) begin
            step;
            chk_a("idle", 4'd0, 4'd0);
        end

        // Single frame of 4'b1101 with explicit expected line sequences.
        data_a = 4'b1101;
        d_en_a = 1'b1;
        step;
        d_en_a = 1'b0;
        for (int k = 0; k < 12; k++) begin
            chk("frame1.state", state_a, (k < 11) ? 4'(k + 1) : 4'd0);
            chk("frame1.scl", {3'b0, scl_a}, {3'b0, frame_scl[11 - k]});
            chk("frame1.sda", {3'b0, sda_a}, {3'b0, frame_sda[11 - k]});
            $display("frame1 k=%0d state=%0d scl=%b sda=%b", k, state_a, scl_a, sda_a);
            step;
        end

        // Data isolation: data changes in B2L and a stray d_en in B1L.
        data_a = 4'b0100;
        d_en_a = 1'b1;
        step;
        d_en_a = 1'b0;
        bits = 4'd0;
        for (int k = 0; k < 11; k++) begin
            chk_a("iso", 4'(k + 1), 4'b0100);
            if (state_a inside {4'd3, 4'd5, 4'd7, 4'd9}) bits = {bits[2:0], sda_a};
            if (state_a == 4'd4) data_a = 4'b1111;
            d_en_a = (state_a == 4'd6);
            step;
        end
        d_en_a = 1'b0;
        chk("iso.bits", bits, 4'b0100);
        repeat (3) begin
            chk_a("iso.idle", 4'd0, 4'd0);
            step;
        end

        // Back-to-back: d_en held high, second word swapped mid-frame.
        data_a = 4'b1011;
        d_en_a = 1'b1;
        step;
        for (int k = 0; k < 11; k++) begin
            chk_a("b2b1", 4'(k + 1), 4'b1011);
            if (state_a == 4'd4) data_a = 4'b0110;
            step;
        end
        chk_a("b2b.gap", 4'd0, 4'd0);
        step;
        d_en_a = 1'b0;
        for (int k = 0; k < 11; k++) begin
            chk_a("b2b2", 4'(k + 1), 4'b0110);
            step;
        end
        chk_a("b2b.end", 4'd0, 4'd0);

        // Mid-frame asynchronous reset in state 6.
        data_a = 4'b1010;
        d_en_a = 1'b1;
        step;
        d_en_a = 1'b0;
        repeat (5) step;
        chk("mid.pre", state_a, 4'd6);
        rst = 1'b0;
        #1;
        chk_a("mid.async", 4'd0, 4'd0);
        step;
        chk_a("mid.held", 4'd0, 4'd0);
        rst = 1'b1;
        step;
        chk_a("mid.rel", 4'd0, 4'd0);
        data_a = 4'b0011;
        d_en_a = 1'b1;
        step;
        d_en_a = 1'b0;
        for (int k = 0; k < 11; k++) begin
            chk_a("clean", 4'(k + 1), 4'b0011);
            step;
        end
        chk_a("clean.end", 4'd0, 4'd0);

        // PHASE_CYCLES=3: every state held three cycles.
        chk("p3.pre", state_b, 4'd0);
        data_b = 4'b1101;
        d_en_b = 1'b1;
        step;
        d_en_b = 1'b0;
        data_b = 4'b0000;
        for (int s = 1; s < 12; s++) begin
            for (int r = 0; r < 3; r++) begin
                chk("p3.state", state_b, 4'(s));
                chk("p3.scl", {3'b0, scl_b}, {3'b0, exp_scl(4'(s))});
                chk("p3.sda", {3'b0, sda_b}, {3'b0, exp_sda(4'(s), 4'b1101)});
                step;
            end
        end
        chk("p3.end.state", state_b, 4'd0);
        chk("p3.end.lines", {2'b0, scl_b, sda_b}, 4'b0011);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
